bcd_updown_counter: RTL and testbench

- Two-digit BCD up/down counter driven by two raw push-buttons, for user input.
- Each button passes through a 2-FF synchronizer and a debouncer, then a rising-edge detector that produces a one-cycle press pulse.
- Each press pulse increments or decrements the count.
- The ones and tens digits feed din0/din1 of the downstream 7-segment controller directly.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/bcd_updown_counter.sv | 104 ++++++++++
 tb/tb_bcd_updown_counter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the button-driven BCD counter and its
// downstream 7-segment path.
package seg7_pkg;

    localparam int BCD_W          = 4;
    localparam int CLK_HZ         = 16_000_000;
    // 1 ms of stable level at the system clock
    localparam int DEB_CYCLES_DEF = CLK_HZ / 1000;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_UP,
        CNT_DOWN,
        CNT_CLR
    } cnt_op_e;

    // Resolve the per-cycle counter action: clear beats everything, and
    // simultaneous up/down presses cancel each other out.
    function automatic cnt_op_e decode_op(input logic clr, input logic up, input logic dn);
        if (clr)            return CNT_CLR;
        else if (up && dn)  return CNT_HOLD;
        else if (up)        return CNT_UP;
        else if (dn)        return CNT_DOWN;
        else                return CNT_HOLD;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-FF synchronizer, level debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce
    import seg7_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          deb_q, deb_d;
    logic          deb_dly_q, deb_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: synchronize, then require CNT_LAST+1 stable cycles of a
    // differing level before the debounced level follows it.
    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        deb_dly_d = deb_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any debounce in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
        end
    end

    // Only the debounced rising edge is a press; releases are ignored.
    assign press = deb_q & ~deb_dly_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter fed by two debounced push-buttons. The
// count wraps between 0 and MAX_COUNT; digits drive the 7-segment inputs.
module bcd_updown_counter
    import seg7_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int MAX_COUNT  = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             clr,
    output logic [BCD_W-1:0] dout0,
    output logic [BCD_W-1:0] dout1,
    output logic             wrap
);

    localparam bcd_t MAX_ONES = bcd_t'(MAX_COUNT % 10);
    localparam bcd_t MAX_TENS = bcd_t'(MAX_COUNT / 10);
    localparam bcd_t NINE     = bcd_t'(9);

    logic    up_press, dn_press;
    cnt_op_e op;
    logic    at_max, at_zero;
    bcd_t    ones_q, ones_d;
    bcd_t    tens_q, tens_d;
    logic    wrap_q, wrap_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .press (up_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .press (dn_press)
    );

    assign op      = decode_op(clr, up_press, dn_press);
    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero = (tens_q == '0) && (ones_q == '0);

    // Next count: BCD increment/decrement with carry/borrow into tens and
    // wrap between 0 and MAX_COUNT, flagging the wrap for one cycle.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        case (op)
            CNT_CLR: begin
                ones_d = '0;
                tens_d = '0;
            end
            CNT_UP: begin
                if (at_max) begin
                    ones_d = '0;
                    tens_d = '0;
                    wrap_d = 1'b1;
                end else if (ones_q == NINE) begin
                    ones_d = '0;
                    tens_d = tens_q + 1'b1;
                end else begin
                    ones_d = ones_q + 1'b1;
                end
            end
            CNT_DOWN: begin
                if (at_zero) begin
                    ones_d = MAX_ONES;
                    tens_d = MAX_TENS;
                    wrap_d = 1'b1;
                end else if (ones_q == '0) begin
                    ones_d = NINE;
                    tens_d = tens_q - 1'b1;
                end else begin
                    ones_d = ones_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Count and wrap registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q <= '0;
            tens_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            wrap_q <= wrap_d;
        end
    end

    assign dout0 = ones_q;
    assign dout1 = tens_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: two instances (MAX_COUNT 99 and 59)
// share the same button/clear/reset stimulus with DEB_CYCLES=4.
module tb_bcd_updown_counter;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] a0, a1, b0, b1;
    logic       aw, bw;

    int errors = 0;
    int checks = 0;
    int inv_errs = 0;
    int inv_checks = 0;

    bcd_updown_counter #(.DEB_CYCLES(DEB), .MAX_COUNT(99)) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .clr(clr),
        .dout0(a0), .dout1(a1), .wrap(aw)
    );

    bcd_updown_counter #(.DEB_CYCLES(DEB), .MAX_COUNT(59)) dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .clr(clr),
        .dout0(b0), .dout1(b1), .wrap(bw)
    );

    always #5 clk = ~clk;

    // Digit validity and range, sampled every cycle away from the edge
    always @(negedge clk) begin
        if (rst) begin
            inv_checks++;
            if (a0 > 9 || a1 > 9 || b0 > 9 || b1 > 9 ||
                (a1 * 10 + a0) > 99 || (b1 * 10 + b0) > 59) begin
                inv_errs++;
                $display("FAIL bcd_invariant: a=%h%h b=%h%h required valid BCD within range",
                         a1, a0, b1, b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, counting wrap-high cycles on each instance
    task automatic hold(input int n, output int wa, output int wb);
        wa = 0;
        wb = 0;
        repeat (n) begin
            tick();
            wa += int'(aw);
            wb += int'(bw);
        end
    endtask

    // Clean press and release of the selected buttons
    task automatic press(input logic u, input logic d, output int wa, output int wb);
        int xa, xb;
        btn_up   = u;
        btn_down = d;
        hold(DEB + 4, wa, wb);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        hold(DEB + 4, xa, xb);
        wa += xa;
        wb += xb;
    endtask

    task automatic drive(input logic u, input logic d, input int n);
        btn_up   = u;
        btn_down = d;
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int wa, wb;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({a1, a0, aw, b1, b0, bw} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: a=%h%h w=%b b=%h%h w=%b required 00/0", a1, a0, aw, b1, b0, bw);
        end
        rst = 1'b1;
        tick();
        press(1'b1, 1'b0, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h01 || {b1, b0} !== 8'h01) begin
            errors++;
            $display("FAIL first_press: a=%h%h b=%h%h required 01", a1, a0, b1, b0);
        end
        // asynchronous assertion mid-cycle
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({a1, a0, aw, b1, b0, bw} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: a=%h%h w=%b b=%h%h required 00/0", a1, a0, aw, b1, b0);
        end
        // press in flight when reset hits, button still held at release
        tick();
        rst = 1'b1;
        tick();
        btn_up = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        // next edge is E; count must move exactly at E+6
        repeat (6) tick();
        checks++;
        if ({a1, a0} !== 8'h00) begin
            errors++;
            $display("FAIL latency_e5: a=%h%h required 00", a1, a0);
        end
        tick();
        checks++;
        if ({a1, a0} !== 8'h01 || aw !== 1'b0) begin
            errors++;
            $display("FAIL latency_e6: a=%h%h w=%b required 01/0", a1, a0, aw);
        end
        repeat (20) tick();
        checks++;
        if ({a1, a0} !== 8'h01 || {b1, b0} !== 8'h01) begin
            errors++;
            $display("FAIL held_no_repeat: a=%h%h b=%h%h required 01", a1, a0, b1, b0);
        end
        drive(1'b0, 1'b0, DEB + 4);
    endtask

    task automatic test_glitch();
        logic [9:0] pat;
        do_clear();
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 12);
        checks++;
        if ({a1, a0} !== 8'h00) begin
            errors++;
            $display("FAIL glitch_3cyc: a=%h%h required 00", a1, a0);
        end
        pat = 10'b1011010011;
        for (int i = 9; i >= 0; i--) drive(pat[i], 1'b0, 1);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, DEB + 4);
        checks++;
        if ({a1, a0} !== 8'h01 || {b1, b0} !== 8'h01) begin
            errors++;
            $display("FAIL bounce_one_inc: a=%h%h b=%h%h required 01", a1, a0, b1, b0);
        end
    endtask

    task automatic test_wrap();
        int wa, wb;
        do_clear();
        press(1'b0, 1'b1, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h99 || wa !== 1) begin
            errors++;
            $display("FAIL wrap_down_99: a=%h%h wraps=%0d required 99/1", a1, a0, wa);
        end
        checks++;
        if ({b1, b0} !== 8'h59 || wb !== 1) begin
            errors++;
            $display("FAIL wrap_down_59: b=%h%h wraps=%0d required 59/1", b1, b0, wb);
        end
        press(1'b1, 1'b0, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h00 || wa !== 1) begin
            errors++;
            $display("FAIL wrap_up_99: a=%h%h wraps=%0d required 00/1", a1, a0, wa);
        end
        checks++;
        if ({b1, b0} !== 8'h00 || wb !== 1) begin
            errors++;
            $display("FAIL wrap_up_59: b=%h%h wraps=%0d required 00/1", b1, b0, wb);
        end
        repeat (9) press(1'b1, 1'b0, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h09 || {b1, b0} !== 8'h09) begin
            errors++;
            $display("FAIL count_09: a=%h%h b=%h%h required 09", a1, a0, b1, b0);
        end
        press(1'b1, 1'b0, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h10 || {b1, b0} !== 8'h10 || wa !== 0 || wb !== 0) begin
            errors++;
            $display("FAIL carry_09_10: a=%h%h b=%h%h wraps=%0d/%0d required 10 no wrap",
                     a1, a0, b1, b0, wa, wb);
        end
        press(1'b0, 1'b1, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h09 || {b1, b0} !== 8'h09 || wa !== 0 || wb !== 0) begin
            errors++;
            $display("FAIL borrow_10_09: a=%h%h b=%h%h wraps=%0d/%0d required 09 no wrap",
                     a1, a0, b1, b0, wa, wb);
        end
    endtask

    task automatic test_simultaneous();
        int wa, wb;
        do_clear();
        repeat (42) press(1'b1, 1'b0, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h42 || {b1, b0} !== 8'h42) begin
            errors++;
            $display("FAIL count_42: a=%h%h b=%h%h required 42", a1, a0, b1, b0);
        end
        press(1'b1, 1'b1, wa, wb);
        checks++;
        if ({a1, a0} !== 8'h42 || wa !== 0 || wb !== 0) begin
            errors++;
            $display("FAIL both_buttons: a=%h%h wraps=%0d required 42/0", a1, a0, wa);
        end
        // press pulse is high in the cycle after edge E+5
        btn_up = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({a1, a0} !== 8'h00 || {b1, b0} !== 8'h00) begin
            errors++;
            $display("FAIL clr_over_press: a=%h%h b=%h%h required 00", a1, a0, b1, b0);
        end
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, DEB + 4);
        checks++;
        if ({a1, a0} !== 8'h00) begin
            errors++;
            $display("FAIL clr_press_dropped: a=%h%h required 00", a1, a0);
        end
    endtask

    task automatic test_scoreboard();
        int ea, eb, op, nr;
        logic u, d;
        do_clear();
        ea = 0;
        eb = 0;
        for (int s = 0; s < 500; s++) begin
            op = $urandom_range(0, 2);
            u  = (op != 1);
            d  = (op != 0);
            nr = $urandom_range(0, 3);
            for (int r = 0; r < nr; r++) begin
                drive(u, d, $urandom_range(1, 3));
                drive(1'b0, 1'b0, $urandom_range(1, 3));
            end
            drive(u, d, DEB + 3);
            nr = $urandom_range(0, 3);
            for (int r = 0; r < nr; r++) begin
                drive(1'b0, 1'b0, $urandom_range(1, 3));
                drive(u, d, $urandom_range(1, 3));
            end
            drive(1'b0, 1'b0, DEB + 4);
            if (op == 0) begin
                ea = (ea + 1) % 100;
                eb = (eb + 1) % 60;
            end else if (op == 1) begin
                ea = (ea + 99) % 100;
                eb = (eb + 59) % 60;
            end
            checks++;
            if (int'(a1) * 10 + int'(a0) != ea || int'(b1) * 10 + int'(b0) != eb) begin
                errors++;
                $display("FAIL scoreboard seq %0d: a=%h%h b=%h%h required %0d/%0d",
                         s, a1, a0, b1, b0, ea, eb);
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_errs !== 0 || inv_checks == 0) begin
            errors++;
            $display("FAIL bcd_invariant_total: violations=%0d cycles=%0d required 0 violations",
                     inv_errs, inv_checks);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_scoreboard();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
